// File: rtl/mmio_io_hub.sv
// mmio_io_hub: register-mapped switch/channel/keypad/LED/segment hub with blocking confirm and key reads.
// Define MMIO_TIMEOUT_EN to bound blocking reads by TIMEOUT_CYC cycles (result 32'hFFFF_FFFF, sticky tout).
module mmio_io_hub #(
    parameter logic [31:0] ADDR_BASE  = 32'hFFFF_FC00,
    parameter int          N_IN       = 4,
    parameter int          FIFO_DEPTH = 8,
    parameter int          LED_W      = 16
`ifdef MMIO_TIMEOUT_EN
    , parameter int        TIMEOUT_CYC = 50_000_000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 io_read,
    input  logic                 io_write,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 io_stall,
    input  logic [15:0]          sw_in,
    input  logic [16*N_IN-1:0]   ch_in,
    input  logic                 conf_btn,
    input  logic                 key_valid,
    input  logic [3:0]           key_code,
    output logic [LED_W-1:0]     led_out,
    output logic [31:0]          seg_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT_CONF, WAIT_KEY, DONE} state_t;
    state_t          state_q, state_d;
    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [6:0]      cnt_q;
    logic [31:0]     cap_q, cap_d, seg_q;
    logic [LED_W-1:0] led_q;
    logic [15:0]     ch [8];
    logic [5:0]      off;
    logic            ovf_q, conf_prev_q, tout, tmo;
    logic            hit, rd, wr, empty, full, pop, push, stat_rd, conf_edge;
    logic            unused;

    for (genvar i = 0; i < 8; i++) begin : g_ch
        if (i < N_IN) begin : g_on
            assign ch[i] = ch_in[16*i +: 16];
        end else begin : g_off
            assign ch[i] = '0;
        end
    end

    assign unused    = ^addr[1:0];
    assign hit       = addr[31:8] == ADDR_BASE[31:8];
    assign off       = addr[7:2];
    assign rd        = io_read & hit;
    assign wr        = io_write & hit;
    assign empty     = cnt_q == 7'd0;
    assign full      = cnt_q == 7'(FIFO_DEPTH);
    assign conf_edge = conf_btn & ~conf_prev_q;
    // a push into a full FIFO still lands when the head leaves in the same cycle
    assign push      = key_valid & (~full | pop);
    assign stat_rd   = (state_q == IDLE) & rd & (off == 6'd3);
    assign led_out   = led_q;
    assign seg_out   = seg_q;

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        pop      = 1'b0;
        io_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd && off == 6'd1) begin
                    io_stall = 1'b1;
                    state_d  = WAIT_CONF;
                end else if (rd && off == 6'd2) begin
                    io_stall = empty;
                    pop      = ~empty;
                    state_d  = empty ? WAIT_KEY : IDLE;
                end
            end
            WAIT_CONF: begin
                io_stall = 1'b1;
                if (conf_edge) begin
                    cap_d   = {16'b0, sw_in};
                    state_d = DONE;
                end else if (tmo) begin
                    cap_d   = '1;
                    state_d = DONE;
                end
            end
            WAIT_KEY: begin
                io_stall = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    cap_d   = {28'b0, mem_q[rd_q]};
                    state_d = DONE;
                end else if (tmo) begin
                    cap_d   = '1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (state_q == DONE) rdata = cap_q;
        else if (rd && state_q == IDLE) begin
            case (off)
                6'd0:    rdata = {16'b0, sw_in};
                6'd2:    rdata = empty ? '0 : {28'b0, mem_q[rd_q]};
                6'd3:    rdata = {21'b0, tout, ovf_q, full, empty, cnt_q};
                6'd4:    rdata = 32'(led_q);
                6'd5:    rdata = seg_q;
                default: rdata = (off[5:3] == 3'd1) ? {16'b0, ch[off[2:0]]} : '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            conf_prev_q <= 1'b0;
            led_q       <= '0;
            seg_q       <= '0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            conf_prev_q <= conf_btn;
            wr_q        <= wr_q + PW'(push);
            rd_q        <= rd_q + PW'(pop);
            cnt_q       <= cnt_q + 7'(push) - 7'(pop);
            ovf_q       <= (key_valid & full & ~pop) | (ovf_q & ~stat_rd);
            if (wr && off == 6'd4) led_q <= wdata[LED_W-1:0];
            if (wr && off == 6'd5) seg_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= key_code;
    end

`ifdef MMIO_TIMEOUT_EN
    logic [31:0] tcnt_q;
    logic        tout_q;
    assign tmo  = tcnt_q == 32'(TIMEOUT_CYC - 1);
    assign tout = tout_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
            tout_q <= 1'b0;
        end else begin
            tcnt_q <= (state_q == IDLE) ? '0 : tcnt_q + 32'd1;
            tout_q <= (tmo & (((state_q == WAIT_CONF) & ~conf_edge) | ((state_q == WAIT_KEY) & empty)))
                      | (tout_q & ~stat_rd);
        end
    end
`else
    assign tmo  = 1'b0;
    assign tout = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_io_hub.sv
// tb_mmio_io_hub: directed checks of the IO hub register map, keypad FIFO and blocking reads.
module tb_mmio_io_hub;
    localparam logic [31:0] BASE = 32'hFFFF_FC00;
    logic        clk = 1'b0, rst = 1'b1, io_read = 1'b0, io_write = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        io_stall;
    logic [15:0] sw_in = '0;
    logic [63:0] ch_in = '0;
    logic        conf_btn = 1'b0, key_valid = 1'b0;
    logic [3:0]  key_code = '0;
    logic [15:0] led_out;
    logic [31:0] seg_out;
    int          n_tests = 0, n_fail = 0, n;

    mmio_io_hub #(
`ifdef MMIO_TIMEOUT_EN
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .io_read(io_read), .io_write(io_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .io_stall(io_stall),
        .sw_in(sw_in), .ch_in(ch_in), .conf_btn(conf_btn),
        .key_valid(key_valid), .key_code(key_code),
        .led_out(led_out), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] o, input logic [31:0] exp, input string tag);
        @(negedge clk);
        addr = {BASE[31:8], o};
        io_read = 1'b1;
        #1;
        chk(tag, rdata, exp);
        chk({tag, "_stall"}, {31'b0, io_stall}, 32'd0);
        @(negedge clk);
        io_read = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wdata = d;
        io_write = 1'b1;
        @(negedge clk);
        io_write = 1'b0;
    endtask

    task automatic push_key(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_seg", seg_out, 32'd0);
        chk("rst_stall", {31'b0, io_stall}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rd(8'h10, 32'd0, "led_rst");
        rd(8'h14, 32'd0, "seg_rst");
        rd(8'h0C, 32'h080, "stat_rst");

        @(negedge clk);
        addr = {BASE[31:8], 8'h10};
        wdata = 32'h1234_ABCD;
        io_write = 1'b1;
        #1;
        chk("led_pre", 32'(led_out), 32'd0);
        @(negedge clk);
        io_write = 1'b0;
        chk("led_post", 32'(led_out), 32'hABCD);
        rd(8'h10, 32'h0000_ABCD, "led_rd");
        wr({BASE[31:8], 8'h14}, 32'h1234_5678);
        chk("seg_out", seg_out, 32'h1234_5678);
        rd(8'h14, 32'h1234_5678, "seg_rd");
        wr(32'h0000_0010, 32'h0000_1111);
        chk("miss_wr", 32'(led_out), 32'hABCD);
        sw_in = 16'h5A3C;
        ch_in = 64'h4444_3333_2222_1111;
        rd(8'h00, 32'h5A3C, "sw");
        rd(8'h20, 32'h1111, "ch0");
        rd(8'h2C, 32'h4444, "ch3");
        rd(8'h30, 32'd0, "ch_n");
        rd(8'h18, 32'd0, "unmapped");
        @(negedge clk);
        addr = 32'h0000_0000;
        io_read = 1'b1;
        #1;
        chk("miss_rd", rdata, 32'd0);
        @(negedge clk);
        io_read = 1'b0;

        // blocking confirm: button already high at the read, edge at cycle 10
        @(negedge clk);
        sw_in = 16'h0055;
        conf_btn = 1'b1;
        addr = {BASE[31:8], 8'h04};
        io_read = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 5) conf_btn = 1'b0;
            if (k == 8) sw_in = 16'h00AA;
            if (k == 10) conf_btn = 1'b1;
            #1;
            if (!io_stall) break;
            n++;
            @(negedge clk);
        end
        chk("conf_stall_cyc", 32'(n), 32'd11);
        chk("conf_rdata", rdata, 32'h0000_00AA);
        @(negedge clk);
        io_read = 1'b0;
        conf_btn = 1'b0;
        #1;
        chk("conf_release", {31'b0, io_stall}, 32'd0);

        for (int i = 1; i <= 9; i++) push_key(4'(i));
        rd(8'h0C, 32'h308, "stat_ovf");
        rd(8'h08, 32'd1, "pop1");
        rd(8'h0C, 32'h007, "stat_7");
        for (int i = 2; i <= 8; i++) rd(8'h08, 32'(i), $sformatf("pop%0d", i));
        rd(8'h0C, 32'h080, "stat_drained");

        for (int i = 1; i <= 8; i++) push_key(4'(i));
        @(negedge clk);
        key_valid = 1'b1;
        key_code = 4'hA;
        addr = {BASE[31:8], 8'h08};
        io_read = 1'b1;
        #1;
        chk("full_pushpop", rdata, 32'd1);
        @(negedge clk);
        key_valid = 1'b0;
        io_read = 1'b0;
        rd(8'h0C, 32'h108, "stat_full_nopovf");
        for (int i = 0; i < 8; i++) rd(8'h08, (i < 7) ? 32'(i + 2) : 32'hA, $sformatf("drain%0d", i));

        // blocking key read: key arrives at cycle 3
        @(negedge clk);
        addr = {BASE[31:8], 8'h08};
        io_read = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            key_valid = (k == 3);
            key_code = 4'd5;
            #1;
            if (!io_stall) break;
            n++;
            @(negedge clk);
        end
        chk("key_stall_cyc", 32'(n), 32'd5);
        chk("key_rdata", rdata, 32'd5);
        @(negedge clk);
        io_read = 1'b0;
        key_valid = 1'b0;
        rd(8'h0C, 32'h080, "stat_after_key");

        @(negedge clk);
        addr = {BASE[31:8], 8'h08};
        io_read = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        io_read = 1'b0;
        #1;
        chk("rst_pre_stall", {31'b0, io_stall}, 32'd1);
        @(negedge clk);
        chk("rst_mid_stall", {31'b0, io_stall}, 32'd0);
        chk("rst_mid_led", 32'(led_out), 32'd0);
        rst = 1'b0;

`ifdef MMIO_TIMEOUT_EN
        @(negedge clk);
        addr = {BASE[31:8], 8'h08};
        io_read = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (!io_stall) break;
            n++;
            @(negedge clk);
        end
        chk("tout_cyc", 32'(n), 32'd17);
        chk("tout_rdata", rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        io_read = 1'b0;
        rd(8'h0C, 32'h480, "stat_tout");
        rd(8'h0C, 32'h080, "stat_tout_clr");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
